// File: rtl/logic_gate_pipe.sv
// WIDTH-bit bitwise logic unit (NAND by default) feeding a STAGES-deep elastic
// valid/ready pipeline; also counts delivered output beats.
module logic_gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic [15:0]      beat_cnt
);

  function automatic logic [WIDTH-1:0] f_logic_op(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [2:0]       op
  );
    logic [WIDTH-1:0] y;
    case (op)
      3'd0:    y = ~(a & b);
      3'd1:    y = a & b;
      3'd2:    y = ~(a | b);
      3'd3:    y = a | b;
      3'd4:    y = a ^ b;
      3'd5:    y = ~(a ^ b);
      3'd6:    y = ~a;
      default: y = a;
    endcase
    return y;
  endfunction

  logic [STAGES-1:0] r_vld_p;
  logic [WIDTH-1:0]  r_y_p [STAGES];
  logic [STAGES-1:0] r_zero_p;
  logic [15:0]       r_beat_cnt;

  logic [WIDTH-1:0]  w_y;
  logic              w_zero;
  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_below_mask;

  assign w_y    = f_logic_op(in_a, in_b, in_op);
  assign w_zero = (w_y == '0);

  // A stage can load when it or any stage downstream of it is empty, or the
  // sink is taking the last beat: the whole chain then shifts by one.
  always_comb begin
    w_load       = '0;
    w_below_mask = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_load[k]       = out_ready | ~(&(r_vld_p | w_below_mask));
      w_below_mask[k] = 1'b1;
    end
  end

  assign in_ready  = rst_n & w_load[0];
  assign out_valid = r_vld_p[STAGES-1];
  assign out_y     = r_y_p[STAGES-1];
  assign out_zero  = r_zero_p[STAGES-1];
  assign beat_cnt  = r_beat_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p    <= '0;
      r_zero_p   <= '0;
      r_beat_cnt <= '0;
      for (int k = 0; k < STAGES; k++) r_y_p[k] <= '0;
    end else begin
      if (out_valid && out_ready) r_beat_cnt <= r_beat_cnt + 16'd1;
      // stage 0: capture the computed result
      if (w_load[0]) begin
        r_vld_p[0] <= in_valid;
        if (in_valid) begin
          r_y_p[0]    <= w_y;
          r_zero_p[0] <= w_zero;
        end
      end
      // stages 1..STAGES-1: carry {valid, y, zero} unchanged
      for (int k = 1; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_vld_p[k] <= r_vld_p[k-1];
          if (r_vld_p[k-1]) begin
            r_y_p[k]    <= r_y_p[k-1];
            r_zero_p[k] <= r_zero_p[k-1];
          end
        end
      end
    end
  end

endmodule
